// File: rtl/data_mem_unit.sv
// Byte-serial data memory for the MEM stage: one byte per cycle, loads come back
// as sign/zero-extended 32-bit lanes so writeback needs no size handling.
module data_mem_unit #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [7:0]  data_from_mem [0:3],
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic                write_q, write_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [7:0]          buf_q [0:3];
    logic [7:0]          buf_d [0:3];
    logic [7:0]          lane_q [0:3];
    logic [7:0]          lane_d [0:3];
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;

    logic [7:0]          mem [2**ADDR_W];
    logic [ADDR_W-1:0]   byte_addr;
    logic [7:0]          mem_rdata;
    logic                mem_we;
    logic                accept;
    logic                req_err;
    logic [1:0]          last_k;
    logic                sign_bit;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W];

    // Width-ADDR_W add gives the required modulo wrap for free.
    assign byte_addr = addr_q + ADDR_W'(k_q);
    assign mem_rdata = mem[byte_addr];
    assign mem_we    = (state_q == ACCESS) && write_q && !rst;
    assign accept    = req_valid && ready_q;
    assign last_k    = (funct3_q[1:0] == 2'b10) ? 2'd3 : {1'b0, funct3_q[0]};

    always_comb begin
        req_err = 1'b0;
        case (funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = addr[0];
            3'b010:  req_err = (addr[1:0] != 2'b00);
            3'b100:  req_err = req_write;
            3'b101:  req_err = req_write || addr[0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        lane_d   = lane_q;
        rsp_err_d = 1'b0;
        sign_bit = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d  = req_write;
                    funct3_d = funct3;
                    addr_d   = addr[ADDR_W-1:0];
                    wdata_d  = wdata;
                    k_d      = 2'd0;
                    if (req_err) begin
                        state_d   = DONE;
                        rsp_err_d = 1'b1;
                        for (int i = 0; i < 4; i++) lane_d[i] = 8'h00;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                buf_d[k_q] = mem_rdata;
                if (k_q == last_k) begin
                    state_d = DONE;
                    k_d     = 2'd0;
                    // Extension is resolved here so lanes only change on DONE entry.
                    sign_bit = !funct3_q[2] && (funct3_q[0] ? buf_d[1][7] : buf_d[0][7]);
                    lane_d[0] = buf_d[0];
                    lane_d[1] = (funct3_q[1:0] == 2'b00) ? {8{sign_bit}} : buf_d[1];
                    lane_d[2] = funct3_q[1] ? buf_d[2] : {8{sign_bit}};
                    lane_d[3] = funct3_q[1] ? buf_d[3] : {8{sign_bit}};
                    if (write_q) begin
                        for (int i = 0; i < 4; i++) lane_d[i] = 8'h00;
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d     = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            write_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i]  <= 8'h00;
                lane_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            buf_q       <= buf_d;
            lane_q      <= lane_d;
        end
    end

    // Storage is deliberately not reset; an aborted store keeps the bytes it wrote.
    always_ff @(posedge clk) begin
        if (mem_we) mem[byte_addr] <= wdata_q[8*k_q +: 8];
    end

    assign req_ready     = ready_q;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign data_from_mem = lane_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: sizes, extension, errors, back-to-back, wrap, reset abort.
module tb_data_mem_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [7:0]  data_from_mem [0:3];
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_unit #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .data_from_mem(data_from_mem),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lanes();
        return {data_from_mem[3], data_from_mem[2], data_from_mem[1], data_from_mem[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns latency (-1 on timeout), err, lanes, busy cycle count.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic err,
                          output logic [31:0] data, output int busy_n);
        int wn;
        req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = d;
        wn = 0;
        while (!req_ready && wn < 50) begin
            @(posedge clk); #1; wn++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'bx; funct3 = 3'bxxx; addr = 32'hx; wdata = 32'hx;
        lat = -1; err = 1'bx; data = 32'hx; busy_n = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy) busy_n++;
            if (rsp_valid) begin
                lat = c; err = rsp_err; data = lanes();
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (busy) busy_n++;
    endtask

    int          lat, bn, acc_n, rsp_n, bad_n;
    logic        err;
    logic [31:0] dat;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_rsp",   {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("reset_lanes", lanes(), 32'h0);

        // Word store then load
        do_req(1, 3'b010, 32'h010, 32'hDEADBEEF, lat, err, dat, bn);
        chk("sw_lat", 32'(lat), 32'd5);
        chk("sw_err", 32'(err), 32'd0);
        chk("sw_lanes", dat, 32'h0);
        do_req(0, 3'b010, 32'h010, 32'h0, lat, err, dat, bn);
        chk("lw_lat", 32'(lat), 32'd5);
        chk("lw_data", dat, 32'hDEADBEEF);
        chk("lw_busy", 32'(bn), 32'd5);
        chk("lw_hold", lanes(), 32'hDEADBEEF);

        // Byte sign/zero extension
        do_req(1, 3'b010, 32'h000, 32'h03020100, lat, err, dat, bn);
        do_req(1, 3'b000, 32'h003, 32'h00000080, lat, err, dat, bn);
        chk("sb_lat", 32'(lat), 32'd2);
        do_req(0, 3'b000, 32'h003, 32'h0, lat, err, dat, bn);
        chk("lb_lat", 32'(lat), 32'd2);
        chk("lb_data", dat, 32'hFFFFFF80);
        do_req(0, 3'b100, 32'h003, 32'h0, lat, err, dat, bn);
        chk("lbu_data", dat, 32'h00000080);
        do_req(0, 3'b010, 32'h000, 32'h0, lat, err, dat, bn);
        chk("lw0_data", dat, 32'h80020100);

        // Half handling
        do_req(1, 3'b010, 32'h020, 32'hCAFEBABE, lat, err, dat, bn);
        do_req(1, 3'b001, 32'h020, 32'h1234F00D, lat, err, dat, bn);
        chk("sh_lat", 32'(lat), 32'd3);
        do_req(0, 3'b001, 32'h020, 32'h0, lat, err, dat, bn);
        chk("lh_lat", 32'(lat), 32'd3);
        chk("lh_data", dat, 32'hFFFFF00D);
        do_req(0, 3'b101, 32'h020, 32'h0, lat, err, dat, bn);
        chk("lhu_data", dat, 32'h0000F00D);
        do_req(0, 3'b010, 32'h020, 32'h0, lat, err, dat, bn);
        chk("lw20_data", dat, 32'hCAFEF00D);

        // Errors
        do_req(1, 3'b001, 32'h021, 32'h55555555, lat, err, dat, bn);
        chk("sh_mis_lat", 32'(lat), 32'd1);
        chk("sh_mis_err", 32'(err), 32'd1);
        chk("sh_mis_lanes", dat, 32'h0);
        do_req(0, 3'b010, 32'h020, 32'h0, lat, err, dat, bn);
        chk("after_err_err", 32'(err), 32'd0);
        chk("after_err_data", dat, 32'hCAFEF00D);
        do_req(0, 3'b011, 32'h000, 32'h0, lat, err, dat, bn);
        chk("f3_011_err", {lat[30:0], err}, {31'd1, 1'b1});
        do_req(1, 3'b100, 32'h000, 32'h0, lat, err, dat, bn);
        chk("sbu_err", {lat[30:0], err}, {31'd1, 1'b1});
        do_req(0, 3'b010, 32'h012, 32'h0, lat, err, dat, bn);
        chk("lw_mis_err", {lat[30:0], err}, {31'd1, 1'b1});

        // Back-to-back with req_valid held high: LB @3, 3-cycle period
        acc_n = 0; rsp_n = 0; bad_n = 0;
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b000; addr = 32'h003;
        for (int i = 1; i <= 30; i++) begin
            if (req_ready) acc_n++;
            if (req_ready && busy) bad_n++;
            @(posedge clk); #1;
            if (rsp_valid) begin
                rsp_n++;
                if (lanes() !== 32'hFFFFFF80 || rsp_err !== 1'b0) bad_n++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_n), 32'd10);
        chk("b2b_rsps", 32'(rsp_n), 32'd10);
        chk("b2b_bad", 32'(bad_n), 32'd0);
        @(posedge clk); #1;

        // Address wrap
        do_req(1, 3'b010, 32'h400, 32'hAABBCCDD, lat, err, dat, bn);
        do_req(0, 3'b010, 32'h000, 32'h0, lat, err, dat, bn);
        chk("wrap_data", dat, 32'hAABBCCDD);

        // Reset during store at k = 2
        do_req(1, 3'b010, 32'h040, 32'hFFFFFFFF, lat, err, dat, bn);
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b010; addr = 32'h040; wdata = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        rsp_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) rsp_n++;
        end
        chk("rst_no_rsp", 32'(rsp_n), 32'd0);
        do_req(0, 3'b010, 32'h040, 32'h0, lat, err, dat, bn);
        chk("rst_data", dat, 32'hFFFF3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
